// File: rtl/regfile_pkg.sv
// Shared constants, types and packing helpers for the multi-port register file.
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 2;
  localparam int ZERO_ADDR          = 0;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  // Bit offset of read port k inside the packed address / data buses.
  function automatic int addr_offset(input int k, input int addr_width);
    return k * addr_width;
  endfunction

  function automatic int data_offset(input int k, input int data_width);
    return k * data_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_nport_if.sv
// Write port plus packed read-port bus between decode/writeback and the register file.
`default_nettype none

interface regfile_nport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);

  logic                           ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]          ctrl_writeReg;
  logic [DATA_WIDTH-1:0]          data_writeReg;
  logic [NUM_READ-1:0]            ctrl_readEnable;
  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
  logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
  logic [NUM_READ-1:0]            data_readValid;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readEnable,
    output ctrl_readReg,
    input  data_readReg,
    input  data_readValid
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readEnable,
    input  ctrl_readReg,
    output data_readReg,
    output data_readValid
  );

endinterface

`default_nettype wire

// File: rtl/regfile_read_mux.sv
// One read port: zero-register / write-bypass / array select with optional output register.
`default_nettype none

module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = 0,
  parameter int ZERO_REG     = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  write_commit,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
);

  logic                  is_zero;
  logic [DATA_WIDTH-1:0] read_value;

  // write_commit already excludes reset and suppressed zero-register writes.
  always_comb begin
    is_zero    = (ZERO_REG != 0) && (read_addr == ADDR_WIDTH'(ZERO_ADDR));
    read_value = mem[read_addr];
    if (is_zero) begin
      read_value = '0;
    end else if (write_commit && (write_addr == read_addr)) begin
      read_value = write_data;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clock, ctrl_reset};
      assign read_data      = read_en ? read_value : '0;
      assign read_valid     = read_en;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= read_en;
          if (read_en) begin
            data_q <= read_value;
          end
        end
      end

      assign read_data  = data_q;
      assign read_valid = valid_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_nport.sv
// Multi-port register file: storage array, write decode and reset clear; one read mux per port.
`default_nettype none

module regfile_nport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ     = DEFAULT_NUM_READ,
  parameter int READ_LATENCY = 0,
  parameter int ZERO_REG     = 1
) (
  input  logic          clock,
  input  logic          ctrl_reset,
  regfile_nport_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          mem [DEPTH];
  logic                           write_commit;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_valid;

  // Single qualified write strobe shared by the array and every bypass path.
  assign write_commit = bus.ctrl_writeEnable && !ctrl_reset &&
                        !((ZERO_REG != 0) && (bus.ctrl_writeReg == ADDR_WIDTH'(ZERO_ADDR)));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_commit) begin
      mem[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  generate
    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
      regfile_read_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .ZERO_REG     (ZERO_REG)
      ) u_read_mux (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .write_commit (write_commit),
        .write_addr   (bus.ctrl_writeReg),
        .write_data   (bus.data_writeReg),
        .mem          (mem),
        .read_en      (bus.ctrl_readEnable[k]),
        .read_addr    (bus.ctrl_readReg[addr_offset(k, ADDR_WIDTH) +: ADDR_WIDTH]),
        .read_data    (rd_data[data_offset(k, DATA_WIDTH) +: DATA_WIDTH]),
        .read_valid   (rd_valid[k])
      );
    end
  endgenerate

  assign bus.data_readReg   = rd_data;
  assign bus.data_readValid = rd_valid;

endmodule

`default_nettype wire

// File: doc/regfile_nport.md
# regfile_nport

Parametrised multi-port register file: the next generation of the processor's register file and read-port logic. It has one write port and `NUM_READ` read ports. The decoder-plus-tri-state read bus is replaced by per-port multiplexers. It adds write-to-read bypass, an optional hardwired zero register, and a selectable registered-read mode with a per-port valid strobe. It sits between decode (read addresses) and writeback (write port) in the core pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: register address width. `DEPTH = 2**ADDR_WIDTH` registers.
- `NUM_READ`, 2: number of independent read ports, 1..8.
- `READ_LATENCY`, 0: 0 = combinational read; 1 = registered read.
- `ZERO_REG`, 1: 1 = register 0 always reads 0 and ignores writes.

Ports:
- `clock`, in, 1: the single clock. All state updates on the rising edge.
- `ctrl_reset`, in, 1: synchronous, active-high reset.
- `ctrl_writeEnable`, in, 1: write strobe.
- `ctrl_writeReg`, in, `ADDR_WIDTH`: write address.
- `data_writeReg`, in, `DATA_WIDTH`: write data.
- `ctrl_readEnable`, in, `NUM_READ`: per-port read request.
- `ctrl_readReg`, in, `NUM_READ*ADDR_WIDTH`: packed read addresses. Port k uses bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `data_readReg`, out, `NUM_READ*DATA_WIDTH`: packed read data, packed the same way.
- `data_readValid`, out, `NUM_READ`: per-port read-data-valid.

## Operation
- Write:
  - At the edge, `mem[ctrl_writeReg] <= data_writeReg` when `ctrl_writeEnable=1`, `ctrl_reset=0`, and not (`ZERO_REG=1` and `ctrl_writeReg=0`).
- Reset:
  - At an edge with `ctrl_reset=1`, all `DEPTH` registers clear to 0.
  - Reset dominates a simultaneous write, which is dropped.
- Read value for port k (`rv_k`):
  - 0 if `ZERO_REG=1` and the address is 0.
  - Otherwise, the bypass value `data_writeReg` if all of these hold: `ctrl_writeEnable=1`, `ctrl_reset=0`, the write address equals the read address, and the write is not suppressed by `ZERO_REG`.
  - Otherwise `mem[addr]`.
- Ports are fully independent. Any number of ports may read the same address in the same cycle, with identical results.
- `READ_LATENCY=0`:
  - `data_readReg[k] = ctrl_readEnable[k] ? rv_k : 0`.
  - `data_readValid[k] = ctrl_readEnable[k]`.
  - Both are purely combinational. Undriven bus states no longer exist.
- `READ_LATENCY=1`:
  - At each edge, for every port with `ctrl_readEnable[k]=1`, the output register captures `rv_k`. This includes the bypass value, so a same-cycle write is visible.
  - `data_readValid[k] <= ctrl_readEnable[k]`.
  - When enable is low, the data register holds its previous value and valid drops to 0.
- Boundary behaviour:
  - A write to the highest address (`DEPTH-1`) is legal.
  - Addresses need no range check because the address width exactly spans `DEPTH`.
  - Reset asserted mid-stream (`READ_LATENCY=1`): on the reset edge, all data and valid output registers clear to 0 and pending reads are discarded.

## Timing
- Reset values:
  - All registers 0.
  - With `READ_LATENCY=1`, `data_readReg` and `data_readValid` are 0.
  - With `READ_LATENCY=0`, the outputs follow the inputs combinationally and return 0 for any enabled read after reset.
- Read latency:
  - `READ_LATENCY=0`: 0 cycles, with write-through in the same cycle.
  - `READ_LATENCY=1`: data and valid appear 1 cycle after the request edge.
- Write latency: the value is stored at the edge of the request. A non-bypassed read sees it from the next cycle onward.
- Throughput: each port accepts one read per cycle; the write port accepts one write per cycle. There are no stalls and no backpressure.
- Reset is sampled only at the rising edge of `clock`. There is no asynchronous path.

## Structure
- Shared package `regfile_pkg`:
  - default width constants;
  - `ZERO_ADDR` constant;
  - a typedef for a `DATA_WIDTH` word and one for an `ADDR_WIDTH` address;
  - the packing helper offsets `k*ADDR_WIDTH` and `k*DATA_WIDTH`.
- Sub-module `regfile_read_mux`:
  - one instance per read port, built by a generate loop;
  - implements the zero / bypass / array selection and the optional output register;
  - `READ_LATENCY` is passed through.
- The top level holds the storage array, the write decode and the reset clear.

## Test plan
- Reset, then a write: reset for 2 cycles, then write `0xDEADBEEF` to r5 and read r5 on port 0 the next cycle. Required: 0 on all ports during reset, then `0xDEADBEEF` with valid=1.
- Zero register: write `0x12345678` to r0 with `ZERO_REG=1`, then read r0. Required: 0. With `ZERO_REG=0`, the same sequence returns `0x12345678`.
- Bypass: in the same cycle, write `0xA5A5A5A5` to r31 and read r31 on ports 0 and 1. Required, `READ_LATENCY=0`: both ports show `0xA5A5A5A5` that cycle. Required, `READ_LATENCY=1`: both show it on the next cycle, with valid=1.
- Registered hold: with `READ_LATENCY=1`, read r3 (holding 7), then deassert enable for 3 cycles. Required: data stays 7 while valid goes 1, 0, 0, 0.
- Reset dominates and aborts: with r9=1, assert `ctrl_reset` together with a write of 2 to r9 and a read of r9. Required: next cycle data=0, valid=0, and r9 reads 0 afterwards.
- Port independence, `NUM_READ=4`: read r1..r4 (holding 10..13) on ports 0..3. Required: each port returns its own value and no port disturbs another.
